// File: rtl/rx_frame_filter_if.sv
// Receive-side bus bundle for rx_frame_filter.
// The MAC side (rx_*) and the released-byte side (out_*) share one bundle.
// The master modport is the environment: it drives MAC bytes and out_ready.
// The slave modport is the filter itself.
interface rx_frame_filter_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_good_frame;
  logic       rx_bad_frame;
  logic [7:0] out_data;
  logic       out_data_valid;
  logic       out_data_last;
  logic       out_ready;

  modport master (
    output rx_data, rx_data_valid, rx_good_frame, rx_bad_frame, out_ready,
    input  out_data, out_data_valid, out_data_last
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_good_frame, rx_bad_frame, out_ready,
    output out_data, out_data_valid, out_data_last
  );
endinterface

// File: rtl/rx_frame_filter.sv
// rx_frame_filter: store-and-forward receive filter in the clk125 domain.
// Each frame is buffered and becomes readable only once the MAC flags it good.
// Bad frames, and frames that overflow the buffer, leave no trace downstream.
// Optional statistics counters are enabled by defining RX_FRAME_FILTER_STATS_EN.
module rx_frame_filter #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic              clk125,
  input  logic              reset,
  rx_frame_filter_if.slave  rx_if
`ifdef RX_FRAME_FILTER_STATS_EN
  ,
  output logic [31:0]       good_frame_count,
  output logic [31:0]       bad_frame_count,
  output logic [31:0]       drop_frame_count
`endif
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]      FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PTR_W-1:0]      PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wr_state_t;

  wr_state_t state;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic              lastbit [DEPTH];

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      commit_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      occupancy;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_addr_prev;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic strobe;
  logic good_evt;
  logic bad_evt;
  logic byte_evt;
  logic buf_full;
  logic data_we;
  logic last_we;
  logic last_val;
  logic [ADDR_WIDTH-1:0] last_addr;

  logic              rd_en_p0;
  logic [DATA_W-1:0] out_data_p1;
  logic              last_p1;
  logic              vld_p1;

  // A simultaneous good+bad pair is a bad frame; a byte alongside any strobe is dropped.
  assign strobe    = rx_if.rx_good_frame | rx_if.rx_bad_frame;
  assign bad_evt   = rx_if.rx_bad_frame;
  assign good_evt  = rx_if.rx_good_frame & ~rx_if.rx_bad_frame;
  assign byte_evt  = rx_if.rx_data_valid & ~strobe;

  assign occupancy    = wr_ptr - rd_ptr;
  assign buf_full     = (occupancy == FULL_OCC);
  assign wr_addr      = wr_ptr[ADDR_WIDTH-1:0];
  assign wr_addr_prev = wr_addr - ADDR_ONE;
  assign rd_addr      = rd_ptr[ADDR_WIDTH-1:0];

  // Buffer write controls: bytes clear their last flag, a good commit sets the previous one.
  always_comb begin
    data_we   = byte_evt && !buf_full && (state != DISCARD);
    last_we   = data_we || ((state == RECV) && good_evt);
    last_val  = !data_we;
    last_addr = data_we ? wr_addr : wr_addr_prev;
  end

  // Write-side FSM: accept bytes, commit on good, rewind on bad or overflow.
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (byte_evt) begin
            if (buf_full) begin
              state <= DISCARD;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              state  <= RECV;
            end
          end
        end
        RECV: begin
          if (bad_evt) begin
            wr_ptr <= commit_ptr;
            state  <= IDLE;
          end else if (good_evt) begin
            commit_ptr <= wr_ptr;
            state      <= IDLE;
          end else if (rx_if.rx_data_valid) begin
            if (buf_full) begin
              wr_ptr <= commit_ptr;
              state  <= DISCARD;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
            end
          end
        end
        DISCARD: begin
          if (strobe) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer storage: data only, no reset needed since pointers gate every read.
  always_ff @(posedge clk125) begin
    if (data_we) begin
      mem[wr_addr] <= rx_if.rx_data;
    end
    if (last_we) begin
      lastbit[last_addr] <= last_val;
    end
  end

  // Issue a read only below commit_ptr and when the output register can take it.
  assign rd_en_p0 = (rd_ptr != commit_ptr) && (!vld_p1 || rx_if.out_ready);

  // ---- stage p0 -> p1: synchronous RAM read straight into the output register ----
  // Output register: load on read, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      out_data_p1 <= '0;
      last_p1     <= 1'b0;
      vld_p1      <= 1'b0;
    end else if (rd_en_p0) begin
      rd_ptr      <= rd_ptr + PTR_ONE;
      out_data_p1 <= mem[rd_addr];
      last_p1     <= lastbit[rd_addr];
      vld_p1      <= 1'b1;
    end else if (rx_if.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign rx_if.out_data       = out_data_p1;
  assign rx_if.out_data_valid = vld_p1;
  assign rx_if.out_data_last  = last_p1;

`ifdef RX_FRAME_FILTER_STATS_EN
  // Frame statistics: zero-byte frames (strobe in IDLE) move no counter.
  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      good_frame_count <= '0;
      bad_frame_count  <= '0;
      drop_frame_count <= '0;
    end else begin
      if ((state == RECV) && good_evt) begin
        good_frame_count <= good_frame_count + 32'd1;
      end
      if ((state != IDLE) && bad_evt) begin
        bad_frame_count <= bad_frame_count + 32'd1;
      end
      if ((state == DISCARD) && strobe) begin
        drop_frame_count <= drop_frame_count + 32'd1;
      end
    end
  end
`endif

endmodule
